// File: rtl/uart_alu_sequencer.sv
// Sequencer for the UART-RX -> ALU -> UART-TX path: gathers A, B and opcode,
// waits out the ALU latency, launches one TX byte and recovers from lost bytes.
module uart_alu_sequencer #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int NB_TO   = 16,
    parameter int TIMEOUT = 50000,
    parameter int ALU_LAT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_rx_done_tick,
    input  logic [DBIT-1:0]  i_rx_data,
    input  logic [DBIT-1:0]  i_alu_result,
    input  logic             i_tx_done_tick,
    output logic [DBIT-1:0]  o_data_a,
    output logic [DBIT-1:0]  o_data_b,
    output logic [NB_OP-1:0] o_operation,
    output logic             o_tx_start,
    output logic [DBIT-1:0]  o_tx_data,
    output logic             o_busy,
    output logic             o_timeout_err,
    output logic             o_overrun_err
);

    localparam int NB_LAT = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [NB_TO-1:0]  TO_LAST  = NB_TO'(TIMEOUT - 1);
    localparam logic [NB_LAT-1:0] LAT_LAST = NB_LAT'(ALU_LAT - 1);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        WAIT_TX
    } state_t;

    state_t            state, state_nxt;
    logic [DBIT-1:0]   data_a_nxt, data_b_nxt, tx_data_nxt;
    logic [NB_OP-1:0]  operation_nxt;
    logic              tx_start_nxt, timeout_nxt, overrun_nxt;
    logic              ov_pend, ov_pend_nxt;
    logic [NB_TO-1:0]  tocnt, tocnt_nxt;
    logic [NB_LAT-1:0] latcnt, latcnt_nxt;
    logic              expired;

    assign expired = (tocnt == TO_LAST);
    assign o_busy  = (state != GET_A);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= GET_A;
            o_data_a      <= '0;
            o_data_b      <= '0;
            o_operation   <= '0;
            o_tx_data     <= '0;
            o_tx_start    <= 1'b0;
            o_timeout_err <= 1'b0;
            o_overrun_err <= 1'b0;
            ov_pend       <= 1'b0;
            tocnt         <= '0;
            latcnt        <= '0;
        end else begin
            state         <= state_nxt;
            o_data_a      <= data_a_nxt;
            o_data_b      <= data_b_nxt;
            o_operation   <= operation_nxt;
            o_tx_data     <= tx_data_nxt;
            o_tx_start    <= tx_start_nxt;
            o_timeout_err <= timeout_nxt;
            o_overrun_err <= overrun_nxt;
            ov_pend       <= ov_pend_nxt;
            tocnt         <= tocnt_nxt;
            latcnt        <= latcnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        data_a_nxt    = o_data_a;
        data_b_nxt    = o_data_b;
        operation_nxt = o_operation;
        tx_data_nxt   = o_tx_data;
        tx_start_nxt  = 1'b0;
        timeout_nxt   = 1'b0;
        overrun_nxt   = ov_pend;
        ov_pend_nxt   = 1'b0;
        tocnt_nxt     = tocnt;
        latcnt_nxt    = latcnt;
        unique case (state)
            GET_A: begin
                tocnt_nxt = '0;
                if (i_rx_done_tick) begin
                    data_a_nxt = i_rx_data;
                    state_nxt  = GET_B;
                end
            end
            GET_B: begin
                if (i_rx_done_tick) begin
                    data_b_nxt = i_rx_data;
                    tocnt_nxt  = '0;
                    state_nxt  = GET_OP;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    tocnt_nxt   = '0;
                    state_nxt   = GET_A;
                end else begin
                    tocnt_nxt = tocnt + NB_TO'(1);
                end
            end
            GET_OP: begin
                if (i_rx_done_tick) begin
                    operation_nxt = i_rx_data[NB_OP-1:0];
                    latcnt_nxt    = '0;
                    tocnt_nxt     = '0;
                    state_nxt     = EXEC;
                end else if (expired) begin
                    timeout_nxt = 1'b1;
                    tocnt_nxt   = '0;
                    state_nxt   = GET_A;
                end else begin
                    tocnt_nxt = tocnt + NB_TO'(1);
                end
            end
            EXEC: begin
                latcnt_nxt = latcnt + NB_LAT'(1);
                if (latcnt == LAT_LAST) begin
                    tx_data_nxt  = i_alu_result;
                    tx_start_nxt = 1'b1;
                    state_nxt    = WAIT_TX;
                    // defer a colliding overrun so it never lands on tx_start
                    ov_pend_nxt  = i_rx_done_tick;
                end else begin
                    overrun_nxt = i_rx_done_tick;
                end
            end
            WAIT_TX: begin
                if (i_rx_done_tick) begin
                    overrun_nxt = 1'b1;
                end
                if (i_tx_done_tick) begin
                    state_nxt = GET_A;
                end
            end
            default: state_nxt = GET_A;
        endcase
    end

endmodule
